// File: rtl/spi_flash_responder_pkg.sv
// Shared command codes, FSM state type and constants for the SPI flash responder.
package spi_flash_resp_pkg;

   localparam logic [7:0] CMD_READ      = 8'h03;
   localparam logic [7:0] CMD_FAST_READ = 8'h0B;
   localparam logic [7:0] CMD_RDID      = 8'h9F;

   localparam int unsigned DUMMY_CYCLES = 8;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      DUMMY,
      DATA,
      ID,
      IGNORE
   } state_t;

endpackage

// File: rtl/spi_flash_responder_if.sv
// Byte-memory read port between the flash responder (master) and the attached memory (slave).
interface spi_flash_responder_if #(
   parameter int unsigned MEM_AW = 12
);
   logic [MEM_AW-1:0] mem_addr;
   logic              mem_re;
   logic [7:0]        mem_rdata;

   modport master (
      output mem_addr,
      output mem_re,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr,
      input  mem_re,
      output mem_rdata
   );
endinterface

// File: rtl/spi_flash_responder_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input with single-cycle rise/fall pulses.
module spi_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   last;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync <= {SYNC_STAGES{RST_VAL}};
         last <= RST_VAL;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], d};
         last <= sync[SYNC_STAGES-1];
      end
   end

   assign rise = sync[SYNC_STAGES-1] & ~last;
   assign fall = ~sync[SYNC_STAGES-1] & last;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI NOR-flash responder (mode 0): READ 0x03 and RDID 0x9F served from a synchronous byte memory.
// Optional build macro SPI_FLASH_RESP_FASTREAD_EN adds FAST READ 0x0B with 8 dummy clocks.
module spi_flash_responder
   import spi_flash_resp_pkg::*;
#(
   parameter int unsigned ADDR_W      = 24,
   parameter int unsigned MEM_AW      = 12,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [23:0] JEDEC_ID    = 24'hEF4016
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         spi_sck,
   input  logic                         spi_csn,
   input  logic                         spi_mosi,
   output logic                         spi_miso,
   output logic                         spi_miso_oe,
   spi_flash_responder_if.master        mem,
   output logic                         busy,
   output logic                         cmd_err
);

   localparam logic [7:0]        CNT_ADDR_LAST = 8'(ADDR_W - 1);
   localparam logic [7:0]        CNT_ADDR_DONE = 8'(ADDR_W);
   localparam logic [ADDR_W-1:0] ADDR_ONE      = ADDR_W'(1);

   logic sck_rise, sck_fall, csn_rise, csn_fall;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   mosi_s;

   state_t            state, state_n;
   logic [7:0]        bit_cnt, cnt_n;
   logic [7:0]        cmd_sr, cmd_n;
   logic [7:0]        cmd_byte;
   logic [ADDR_W-1:0] addr, addr_n;
   logic [23:0]       tx_sr, tx_n;
   logic              miso_r, miso_n;
   logic              re_r, re_n;
   logic [MEM_AW-1:0] maddr_r, maddr_n;
   logic              rd_pend, rd_pend_n;
   logic              err_r, err_n;

   // CSn chain resets low so a reset released mid-transfer sees no fall until CSn cycles.
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
      .clk  (clk),
      .rstn (rstn),
      .d    (spi_sck),
      .rise (sck_rise),
      .fall (sck_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_csn_sync (
      .clk  (clk),
      .rstn (rstn),
      .d    (spi_csn),
      .rise (csn_rise),
      .fall (csn_fall)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mosi_sync <= '0;
      end else begin
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      end
   end

   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         bit_cnt <= '0;
         cmd_sr  <= '0;
         addr    <= '0;
         tx_sr   <= '0;
         miso_r  <= 1'b0;
         re_r    <= 1'b0;
         maddr_r <= '0;
         rd_pend <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state   <= state_n;
         bit_cnt <= cnt_n;
         cmd_sr  <= cmd_n;
         addr    <= addr_n;
         tx_sr   <= tx_n;
         miso_r  <= miso_n;
         re_r    <= re_n;
         maddr_r <= maddr_n;
         rd_pend <= rd_pend_n;
         err_r   <= err_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = bit_cnt;
      cmd_n     = cmd_sr;
      addr_n    = addr;
      tx_n      = tx_sr;
      miso_n    = miso_r;
      re_n      = 1'b0;
      maddr_n   = maddr_r;
      rd_pend_n = re_r;
      err_n     = 1'b0;
      cmd_byte  = {cmd_sr[6:0], mosi_s};

      if (csn_rise) begin
         state_n   = IDLE;
         cnt_n     = '0;
         miso_n    = 1'b0;
         rd_pend_n = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (csn_fall) begin
                  state_n = CMD;
                  cnt_n   = '0;
                  cmd_n   = '0;
                  addr_n  = '0;
                  tx_n    = '0;
               end
            end
            CMD: begin
               if (sck_rise) begin
                  cmd_n = cmd_byte;
                  cnt_n = bit_cnt + 8'd1;
                  if (bit_cnt == 8'd7) begin
                     cnt_n = '0;
                     case (cmd_byte)
                        CMD_READ:      state_n = ADDR;
`ifdef SPI_FLASH_RESP_FASTREAD_EN
                        CMD_FAST_READ: state_n = ADDR;
`endif
                        CMD_RDID: begin
                           state_n = ID;
                           tx_n    = JEDEC_ID;
                        end
                        default: begin
                           state_n = IGNORE;
                           err_n   = 1'b1;
                        end
                     endcase
                  end
               end
            end
            ADDR: begin
               // Address complete: wait out the memory read, then hand over the first byte.
               if (rd_pend) begin
                  tx_n  = {mem.mem_rdata, 16'h0000};
                  cnt_n = '0;
`ifdef SPI_FLASH_RESP_FASTREAD_EN
                  state_n = (cmd_sr == CMD_FAST_READ) ? DUMMY : DATA;
`else
                  state_n = DATA;
`endif
               end else if (sck_rise && (bit_cnt != CNT_ADDR_DONE)) begin
                  addr_n = {addr[ADDR_W-2:0], mosi_s};
                  cnt_n  = bit_cnt + 8'd1;
                  if (bit_cnt == CNT_ADDR_LAST) begin
                     re_n    = 1'b1;
                     maddr_n = addr_n[MEM_AW-1:0];
                  end
               end
            end
`ifdef SPI_FLASH_RESP_FASTREAD_EN
            DUMMY: begin
               if (sck_rise) begin
                  cnt_n = bit_cnt + 8'd1;
                  if (bit_cnt == 8'(DUMMY_CYCLES - 1)) begin
                     cnt_n   = '0;
                     state_n = DATA;
                  end
               end
            end
`endif
            DATA: begin
               // Next byte is fetched on the fall driving bit 0 and lands before the following fall.
               if (rd_pend) begin
                  tx_n = {mem.mem_rdata, 16'h0000};
               end
               if (sck_fall) begin
                  miso_n = tx_sr[23];
                  tx_n   = {tx_sr[22:0], 1'b0};
                  cnt_n  = bit_cnt + 8'd1;
                  if (bit_cnt == 8'd7) begin
                     cnt_n   = '0;
                     addr_n  = addr + ADDR_ONE;
                     re_n    = 1'b1;
                     maddr_n = addr_n[MEM_AW-1:0];
                  end
               end
            end
            ID: begin
               if (sck_fall) begin
                  miso_n = tx_sr[23];
                  tx_n   = {tx_sr[22:0], 1'b0};
               end
            end
            IGNORE: begin
               state_n = IGNORE;
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   assign spi_miso_oe  = (state == DATA) || (state == ID);
   assign spi_miso     = miso_r & spi_miso_oe;
   assign busy         = (state != IDLE);
   assign cmd_err      = err_r;
   assign mem.mem_addr = maddr_r;
   assign mem.mem_re   = re_r;

endmodule
